// File: rtl/el2_exu_mul_pipe.sv
// Pipelined XLEN x XLEN integer multiplier (MUL/MULH/MULHSU/MULHU) with
// valid/ready handshake, collapsing bubbles, flush and tag pass-through.
module el2_exu_mul_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_rs1_sign_i,
    input  logic             in_rs2_sign_i,
    input  logic             in_low_i,
    input  logic [XLEN-1:0]  in_rs1_i,
    input  logic [XLEN-1:0]  in_rs2_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);

    localparam int unsigned PW = 2 * XLEN;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] adv;
    logic              accept;
    logic [XLEN-1:0]   res_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];

    logic signed [XLEN:0]   op_a;
    logic signed [XLEN:0]   op_b;
    logic signed [PW-1:0]   prod;
    logic [XLEN-1:0]        res_d;

    // Bits above 2*XLEN-1 never reach the result, so the product is kept modulo 2^(2*XLEN).
    always_comb begin
        op_a  = {in_rs1_sign_i & in_rs1_i[XLEN-1], in_rs1_i};
        op_b  = {in_rs2_sign_i & in_rs2_i[XLEN-1], in_rs2_i};
        prod  = PW'(op_a) * PW'(op_b);
        res_d = in_low_i ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    end

    // Advance chain walks back from the output; 'room' means the stage below can take data.
    always_comb begin
        logic room;
        adv  = '0;
        room = out_ready_i;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            adv[i] = v_q[i] & room;
            room   = ~v_q[i] | adv[i];
        end
        in_ready_o = room;
        accept     = in_valid_i & room & ~flush_i;

        v_d    = '0;
        v_d[0] = accept | (v_q[0] & ~adv[0]);
        for (int i = 1; i < int'(STAGES); i++) begin
            v_d[i] = adv[i-1] | (v_q[i] & ~adv[i]);
        end
        if (flush_i) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                res_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            if (accept) begin
                res_q[0] <= res_d;
                tag_q[0] <= in_tag_i;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (adv[i-1]) begin
                    res_q[i] <= res_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

    assign out_valid_o  = v_q[STAGES-1];
    assign out_result_o = res_q[STAGES-1];
    assign out_tag_o    = tag_q[STAGES-1];
    assign busy_o       = |v_q;

endmodule

// File: tb/tb_el2_exu_mul_pipe.sv
// Self-checking bench for el2_exu_mul_pipe: directed spec vectors plus random
// traffic scored against an arithmetic reference model and an in-flight queue.
module tb_el2_exu_mul_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
);

    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             in_rs1_sign_i;
    logic             in_rs2_sign_i;
    logic             in_low_i;
    logic [XLEN-1:0]  in_rs1_i;
    logic [XLEN-1:0]  in_rs2_i;
    logic [TAG_W-1:0] in_tag_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  out_result_o;
    logic [TAG_W-1:0] out_tag_o;
    logic             busy_o;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_tx     = 0;
    bit   last_acc = 1'b0;
    exp_t q[$];

    el2_exu_mul_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_rs1_sign_i (in_rs1_sign_i),
        .in_rs2_sign_i (in_rs2_sign_i),
        .in_low_i      (in_low_i),
        .in_rs1_i      (in_rs1_i),
        .in_rs2_i      (in_rs2_i),
        .in_tag_i      (in_tag_i),
        .flush_i       (flush_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_result_o  (out_result_o),
        .out_tag_o     (out_tag_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference: operands as mathematical integers, exact product, then pick a half.
    function automatic logic [XLEN-1:0] model(input bit s1, input bit s2, input bit low,
                                              input logic [XLEN-1:0] rs1,
                                              input logic [XLEN-1:0] rs2);
        logic signed [259:0] av;
        logic signed [259:0] bv;
        logic signed [259:0] p;
        av = 260'(rs1);
        bv = 260'(rs2);
        if (s1 && rs1[XLEN-1]) av = av - (260'(1) << XLEN);
        if (s2 && rs2[XLEN-1]) bv = bv - (260'(1) << XLEN);
        p = av * bv;
        return low ? p[XLEN-1:0] : XLEN'(p >>> XLEN);
    endfunction

    function automatic logic [XLEN-1:0] rnd_word();
        logic [XLEN-1:0] w;
        case ($urandom_range(0, 3))
            0:       w = '0;
            1:       w = '1;
            2:       w = XLEN'(1) << (XLEN - 1);
            default: w = XLEN'({$urandom(), $urandom()});
        endcase
        return w;
    endfunction

    task automatic rand_op(input logic [TAG_W-1:0] tag);
        in_rs1_i      = rnd_word();
        in_rs2_i      = rnd_word();
        in_rs1_sign_i = 1'($urandom());
        in_rs2_sign_i = 1'($urandom());
        in_low_i      = 1'($urandom());
        in_tag_i      = tag;
    endtask

    // One clock: observe handshakes before the edge, update the scoreboard, check after it.
    task automatic tick();
        exp_t            e;
        bit              stall_now;
        logic [XLEN-1:0] stall_res;
        logic [TAG_W-1:0] stall_tag;
        #1;
        if (!rst) chk("in_ready", 64'(in_ready_o), 64'(out_ready_i | (q.size() < int'(STAGES))));
        last_acc = 1'b0;
        if (!rst && out_valid_o && out_ready_i) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_valid_o), 64'd0);
            end else begin
                e = q.pop_front();
                chk("result", 64'(out_result_o), 64'(e.res));
                chk("tag", 64'(out_tag_o), 64'(e.tag));
            end
            n_tx++;
        end
        stall_now = !rst && !flush_i && out_valid_o && !out_ready_i;
        stall_res = out_result_o;
        stall_tag = out_tag_o;
        if (rst || flush_i) begin
            q.delete();
        end else if (in_valid_i && in_ready_o) begin
            e.res = model(in_rs1_sign_i, in_rs2_sign_i, in_low_i, in_rs1_i, in_rs2_i);
            e.tag = in_tag_i;
            q.push_back(e);
            last_acc = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("busy", 64'(busy_o), 64'(q.size() != 0));
        if (stall_now) begin
            chk("stall_valid", 64'(out_valid_o), 64'd1);
            chk("stall_result", 64'(out_result_o), 64'(stall_res));
            chk("stall_tag", 64'(out_tag_o), 64'(stall_tag));
        end
    endtask

    // Single op into an empty pipe: latency, literal result and tag, then consume it.
    task automatic run_op(input bit s1, input bit s2, input bit low,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] lit,
                          input string name);
        int n;
        out_ready_i   = 1'b1;
        in_rs1_sign_i = s1;
        in_rs2_sign_i = s2;
        in_low_i      = low;
        in_rs1_i      = a;
        in_rs2_i      = b;
        in_tag_i      = tag;
        in_valid_i    = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n = 1;
        while (!out_valid_o && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(STAGES));
        chk({name, "_value"}, 64'(out_result_o), 64'(lit));
        chk({name, "_tag"}, 64'(out_tag_o), 64'(tag));
        tick();
    endtask

    initial begin
        logic [XLEN-1:0] ones;
        logic [XLEN-1:0] minv;
        int idx;
        int tx0;
        ones = '1;
        minv = XLEN'(1) << (XLEN - 1);

        rst = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        in_rs1_sign_i = 1'b0; in_rs2_sign_i = 1'b0; in_low_i = 1'b0;
        in_rs1_i = '0; in_rs2_i = '0; in_tag_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_result", 64'(out_result_o), 64'd0);
        chk("rst_out_tag", 64'(out_tag_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);

        run_op(1, 1, 1, ones, ones, TAG_W'(3), XLEN'(1), "ss_ones_low");
        run_op(1, 1, 0, ones, ones, TAG_W'(3), '0, "ss_ones_high");
        run_op(0, 0, 0, ones, ones, TAG_W'(4), ones - XLEN'(1), "mulhu_ones");
        run_op(1, 0, 0, ones, ones, TAG_W'(5), ones, "mulhsu_ones");
        run_op(1, 1, 0, minv, minv, TAG_W'(6), XLEN'(1) << (XLEN - 2), "mulh_min");
        run_op(1, 1, 1, minv, minv, TAG_W'(7), '0, "mul_min_low");

        // Back-to-back: 8 transfers must land in exactly 8+STAGES cycles.
        out_ready_i = 1'b1;
        tx0 = n_tx;
        for (int k = 0; k < 8; k++) begin
            rand_op(TAG_W'(k));
            in_valid_i = 1'b1;
            tick();
        end
        in_valid_i = 1'b0;
        repeat (STAGES) tick();
        chk("b2b_count", 64'(n_tx - tx0), 64'd8);

        // Backpressure: only STAGES ops fit while the output is blocked.
        out_ready_i = 1'b0;
        idx = 0;
        rand_op(TAG_W'(8));
        in_valid_i = 1'b1;
        repeat (8) begin
            tick();
            if (last_acc) begin
                idx++;
                if (idx < 5) rand_op(TAG_W'(8 + idx));
                else in_valid_i = 1'b0;
            end
        end
        chk("bp_accepts", 64'(idx), 64'((STAGES < 5) ? STAGES : 5));
        tx0 = n_tx;
        out_ready_i = 1'b1;
        for (int k = 0; k < 40 && (n_tx - tx0) < 5; k++) begin
            tick();
            if (last_acc) begin
                idx++;
                if (idx < 5) rand_op(TAG_W'(8 + idx));
                else in_valid_i = 1'b0;
            end
        end
        in_valid_i = 1'b0;
        chk("bp_drained", 64'(n_tx - tx0), 64'd5);

        // Flush with ops in flight and a new op presented the same cycle.
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_op(TAG_W'(20 + k));
            in_valid_i = 1'b1;
            tick();
        end
        rand_op(TAG_W'(23));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_out_valid", 64'(out_valid_o), 64'd0);
        chk("flush_busy", 64'(busy_o), 64'd0);
        repeat (STAGES + 2) tick();
        run_op(0, 0, 1, XLEN'(11), XLEN'(13), TAG_W'(2), XLEN'(143), "post_flush");

        // Reset mid-stream.
        for (int k = 0; k < 2; k++) begin
            rand_op(TAG_W'(24 + k));
            in_valid_i = 1'b1;
            tick();
        end
        in_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_out_result", 64'(out_result_o), 64'd0);
        chk("mid_rst_out_tag", 64'(out_tag_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        run_op(0, 0, 1, XLEN'(7), XLEN'(6), TAG_W'(9), XLEN'(42), "rst_7x6");

        // Random traffic with backpressure and occasional flush.
        for (int k = 0; k < 400; k++) begin
            in_valid_i = 1'($urandom());
            rand_op(TAG_W'($urandom()));
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 29) == 0);
            tick();
        end
        in_valid_i = 1'b0;
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        for (int k = 0; k < 40 && q.size() != 0; k++) tick();
        tick();
        chk("final_out_valid", 64'(out_valid_o), 64'd0);
        chk("final_busy", 64'(busy_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
